mem_access_stage: RTL and testbench

- EX/MEM pipeline register plus data-memory access controller.
- Sits between the EX stage and the MEM_WB register, which latches every cycle.
- Drives a multi-cycle data memory through a req/ack handshake and stalls upstream stages while an access is outstanding.
- Inserts bubbles (RegWrite_o=0) toward writeback so MEM_WB never commits a half-finished load.

---
 rtl/mem_access_stage.sv | 159 +++++++++++++++
 tb/tb_mem_access_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM pipeline register and data-memory access controller.
// Holds the EX result, drives a req/ack data memory, and stalls upstream while
// an access is outstanding. Bubbles (RegWrite_o=0) are shown toward writeback
// until an access completes.
// Optional build macro: MEM_TIMEOUT_EN enables an ACCESS watchdog that aborts
// after TIMEOUT_CYCLES cycles without mem_ack_i.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic        MemtoReg_i,
   input  logic        RegWrite_i,
   input  logic [31:0] ALUResult_i,
   input  logic [31:0] WriteData_i,
   input  logic [4:0]  RD_i,
   input  logic        flush_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_o,
   output logic        MemtoReg_o,
   output logic        RegWrite_o,
   output logic [31:0] Data_o,
   output logic [31:0] Result_o,
   output logic [4:0]  RD_o,
   output logic        err_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state, state_n;

   logic        s_mem_write;
   logic        s_memtoreg;
   logic        s_regwrite;
   logic [31:0] s_alu;
   logic [31:0] s_wdata;
   logic [4:0]  s_rd;
   logic [31:0] data_q;
   logic        err_q;
   logic        timed_out_q;

   logic        in_access;
   logic        in_mem;
   logic        in_aligned;
   logic        start_access;
   logic        misaligned;
   logic        timeout_hit;

   assign in_access    = (state == ACCESS);
   assign in_mem       = (MemRead_i | MemWrite_i) & ~flush_i;
   assign in_aligned   = (ALUResult_i[1:0] == 2'b00);
   assign start_access = in_mem & in_aligned;
   assign misaligned   = in_mem & ~in_aligned;

`ifdef MEM_TIMEOUT_EN
   logic [31:0] cnt_q;

   assign timeout_hit = in_access && !mem_ack_i && (cnt_q == TIMEOUT_CYCLES - 1);

   // Watchdog: counts ACCESS cycles without ack, restarts from 0 on each entry
   always_ff @(posedge clk_i) begin
      if (rst_i || !in_access) begin
         cnt_q <= '0;
      end else if (!mem_ack_i) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic; IDLE and DONE both accept a new instruction this edge
   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE: state_n = start_access ? ACCESS : IDLE;
         ACCESS:     state_n = (mem_ack_i || timeout_hit) ? DONE : ACCESS;
         default:    state_n = IDLE;
      endcase
   end

   // Stage register: loads when not stalled; flush and misaligned accesses become bubbles
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s_mem_write <= 1'b0;
         s_memtoreg  <= 1'b0;
         s_regwrite  <= 1'b0;
         s_alu       <= '0;
         s_wdata     <= '0;
         s_rd        <= '0;
      end else if (!in_access) begin
         if (flush_i || misaligned) begin
            s_mem_write <= 1'b0;
            s_memtoreg  <= 1'b0;
            s_regwrite  <= 1'b0;
            s_alu       <= '0;
            s_wdata     <= '0;
            s_rd        <= '0;
         end else begin
            s_mem_write <= MemWrite_i;
            s_memtoreg  <= MemtoReg_i;
            // a store (including read+write together) never writes the register file
            s_regwrite  <= RegWrite_i & ~MemWrite_i;
            s_alu       <= ALUResult_i;
            s_wdata     <= WriteData_i;
            s_rd        <= RD_i;
         end
      end
   end

   // Load data capture, error flag and timeout marker for the DONE cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q      <= '0;
         err_q       <= 1'b0;
         timed_out_q <= 1'b0;
      end else begin
         if (in_access && mem_ack_i) begin
            data_q <= mem_rdata_i;
         end
         if ((!in_access && misaligned) || timeout_hit) begin
            err_q <= 1'b1;
         end
         timed_out_q <= timeout_hit;
      end
   end

   // Outputs: memory interface from the stage register, bubble while ACCESS or after a timeout
   always_comb begin
      mem_req_o   = in_access;
      mem_we_o    = in_access & s_mem_write;
      mem_addr_o  = s_alu;
      mem_wdata_o = s_wdata;
      stall_o     = in_access;
      MemtoReg_o  = s_memtoreg;
      RegWrite_o  = s_regwrite & ~in_access & ~timed_out_q;
      Data_o      = data_q;
      Result_o    = s_alu;
      RD_o        = s_rd;
      err_o       = err_q;
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write, memtoreg, regwrite, flush, ack;
   logic [31:0] alu, wdata, rdata;
   logic [4:0]  rd;
   logic        req, we, stall, memtoreg_out, regwrite_out, err;
   logic [31:0] addr, wdata_out, data_out, result_out;
   logic [4:0]  rd_out;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .MemRead_i(mem_read), .MemWrite_i(mem_write), .MemtoReg_i(memtoreg),
      .RegWrite_i(regwrite), .ALUResult_i(alu), .WriteData_i(wdata), .RD_i(rd),
      .flush_i(flush),
      .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata_out),
      .mem_ack_i(ack), .mem_rdata_i(rdata),
      .stall_o(stall), .MemtoReg_o(memtoreg_out), .RegWrite_o(regwrite_out),
      .Data_o(data_out), .Result_o(result_out), .RD_o(rd_out), .err_o(err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input logic m2r, input logic rw,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] r_d);
      mem_read = r; mem_write = w; memtoreg = m2r; regwrite = rw;
      alu = a; wdata = d; rd = r_d;
   endtask

   task automatic bubble();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; ack = 1'b0; rdata = '0;
      bubble();
      tick(); tick();
      rst = 1'b0;

      // reset state
      check("rst_req", {31'b0, req}, 32'd0);
      check("rst_stall", {31'b0, stall}, 32'd0);
      check("rst_regwrite", {31'b0, regwrite_out}, 32'd0);
      check("rst_memtoreg", {31'b0, memtoreg_out}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_data", data_out, 32'd0);
      check("rst_result", result_out, 32'd0);
      check("rst_rd", {27'b0, rd_out}, 32'd0);

      // plain ALU op passes through in one cycle
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 5'd5);
      tick();
      check("alu_regwrite", {31'b0, regwrite_out}, 32'd1);
      check("alu_result", result_out, 32'h10);
      check("alu_rd", {27'b0, rd_out}, 32'd5);
      check("alu_stall", {31'b0, stall}, 32'd0);
      check("alu_req", {31'b0, req}, 32'd0);

      // load at 0x100, ack on the third ACCESS cycle; next ALU op waits upstream
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd7);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h0, 5'd9);
      for (int i = 0; i < 3; i++) begin
         check("ld_req", {31'b0, req}, 32'd1);
         check("ld_stall", {31'b0, stall}, 32'd1);
         check("ld_regwrite_bubble", {31'b0, regwrite_out}, 32'd0);
         check("ld_we", {31'b0, we}, 32'd0);
         check("ld_addr", addr, 32'h100);
         if (i == 2) begin
            ack = 1'b1; rdata = 32'hDEAD_BEEF;
         end
         tick();
      end
      ack = 1'b0; rdata = '0;
      check("ld_done_req", {31'b0, req}, 32'd0);
      check("ld_done_stall", {31'b0, stall}, 32'd0);
      check("ld_done_data", data_out, 32'hDEAD_BEEF);
      check("ld_done_memtoreg", {31'b0, memtoreg_out}, 32'd1);
      check("ld_done_regwrite", {31'b0, regwrite_out}, 32'd1);
      check("ld_done_rd", {27'b0, rd_out}, 32'd7);
      tick();
      check("after_ld_result", result_out, 32'h44);
      check("after_ld_rd", {27'b0, rd_out}, 32'd9);
      check("after_ld_regwrite", {31'b0, regwrite_out}, 32'd1);
      check("after_ld_data_hold", data_out, 32'hDEAD_BEEF);

      // store to 0x200 acked at once, load right behind it
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h1234_5678, 5'd0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd3);
      check("st_req", {31'b0, req}, 32'd1);
      check("st_we", {31'b0, we}, 32'd1);
      check("st_addr", addr, 32'h200);
      check("st_wdata", wdata_out, 32'h1234_5678);
      check("st_regwrite", {31'b0, regwrite_out}, 32'd0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("st_done_req", {31'b0, req}, 32'd0);
      check("st_done_stall", {31'b0, stall}, 32'd0);
      check("st_done_regwrite", {31'b0, regwrite_out}, 32'd0);
      tick();
      bubble();
      check("b2b_req", {31'b0, req}, 32'd1);
      check("b2b_we", {31'b0, we}, 32'd0);
      check("b2b_addr", addr, 32'h300);
      ack = 1'b1; rdata = 32'hCAFE_F00D;
      tick();
      ack = 1'b0; rdata = '0;
      check("b2b_data", data_out, 32'hCAFE_F00D);
      check("b2b_regwrite", {31'b0, regwrite_out}, 32'd1);
      check("b2b_rd", {27'b0, rd_out}, 32'd3);
      tick();
      check("b2b_idle_regwrite", {31'b0, regwrite_out}, 32'd0);
      check("b2b_idle_stall", {31'b0, stall}, 32'd0);

      // misaligned load at 0x102
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd4);
      tick();
      bubble();
      check("mis_req", {31'b0, req}, 32'd0);
      check("mis_err", {31'b0, err}, 32'd1);
      check("mis_regwrite", {31'b0, regwrite_out}, 32'd0);
      check("mis_stall", {31'b0, stall}, 32'd0);
      tick();
      check("mis_err_sticky", {31'b0, err}, 32'd1);

      // ack while idle is ignored
      ack = 1'b1; rdata = 32'h1111_1111;
      tick();
      ack = 1'b0; rdata = '0;
      check("stray_ack_data", data_out, 32'hCAFE_F00D);
      check("stray_ack_req", {31'b0, req}, 32'd0);

      // read and write together behave as a store
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 32'h55, 5'd6);
      tick();
      bubble();
      check("rw_we", {31'b0, we}, 32'd1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("rw_done_regwrite", {31'b0, regwrite_out}, 32'd0);
      tick();

      // flush during a stalled load, then reset in the second ACCESS cycle
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 32'h0, 5'd8);
      tick();
      bubble();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_ign_req", {31'b0, req}, 32'd1);
      check("flush_ign_stall", {31'b0, stall}, 32'd1);
      check("flush_ign_addr", addr, 32'h500);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ack = 1'b1; rdata = 32'h7777_7777;
      check("abort_req", {31'b0, req}, 32'd0);
      check("abort_stall", {31'b0, stall}, 32'd0);
      check("abort_err", {31'b0, err}, 32'd0);
      check("abort_result", result_out, 32'd0);
      check("abort_rd", {27'b0, rd_out}, 32'd0);
      check("abort_memtoreg", {31'b0, memtoreg_out}, 32'd0);
      tick();
      ack = 1'b0; rdata = '0;
      check("late_ack_req", {31'b0, req}, 32'd0);
      check("late_ack_data", data_out, 32'd0);
      check("late_ack_regwrite", {31'b0, regwrite_out}, 32'd0);
      check("late_ack_stall", {31'b0, stall}, 32'd0);

`ifdef MEM_TIMEOUT_EN
      // no ack: watchdog aborts after four request cycles
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h600, 32'h0, 5'd2);
      tick();
      bubble();
      for (int i = 0; i < 4; i++) begin
         check("to_req", {31'b0, req}, 32'd1);
         tick();
      end
      check("to_done_req", {31'b0, req}, 32'd0);
      check("to_done_stall", {31'b0, stall}, 32'd0);
      check("to_done_err", {31'b0, err}, 32'd1);
      check("to_done_regwrite", {31'b0, regwrite_out}, 32'd0);
      tick();
      check("to_idle_req", {31'b0, req}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
